// File: rtl/snake_pkg.sv
// snake_pkg: shared encodings, field limits and helpers for the snake game blocks.
package snake_pkg;
  localparam logic [1:0] ST_RESTART = 2'b00;
  localparam logic [1:0] ST_HOLD    = 2'b01;
  localparam logic [1:0] ST_PLAY    = 2'b10;
  localparam logic [1:0] ST_DEAD    = 2'b11;
  localparam int X_MIN = 1;
  localparam int X_MAX = 75;
  localparam int Y_MIN = 1;
  localparam int Y_MAX = 58;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {CELL_NONE, CELL_HEAD, CELL_BODY, CELL_WALL} cell_t;
  typedef enum logic [2:0] {S_RESTART, S_READY, S_PLAY, S_PAUSE, S_DYING, S_OVER} state_t;
  function automatic logic [1:0] status_of(input state_t s);
    return s == S_RESTART ? ST_RESTART :
           (s == S_READY || s == S_PAUSE) ? ST_HOLD :
           s == S_PLAY ? ST_PLAY : ST_DEAD;
  endfunction
  // compare before subtracting so the period can never wrap below the floor
  function automatic logic [40:0] next_speed(input logic [40:0] spd, dec, lo);
    return (spd >= lo && spd - lo >= dec) ? spd - dec : lo;
  endfunction
endpackage

// File: rtl/snake_game_ctrl_if.sv
// snake_game_ctrl_if: signal bundle between the game sequencer and the snake/apple datapath.
interface snake_game_ctrl_if;
  logic        start_press;
  logic        hit_wall;
  logic        hit_body;
  logic [6:0]  head_x;
  logic [6:0]  head_y;
  logic [6:0]  apple_x;
  logic [6:0]  apple_y;
  logic [6:0]  cube_num;
  logic [1:0]  game_status;
  logic [40:0] speed;
  logic        add_cube;
  logic        apple_req;
  logic        die_flash;
  logic [7:0]  score;
  modport master (
    input  start_press, hit_wall, hit_body, head_x, head_y, apple_x, apple_y, cube_num,
    output game_status, speed, add_cube, apple_req, die_flash, score
  );
  modport slave (
    output start_press, hit_wall, hit_body, head_x, head_y, apple_x, apple_y, cube_num,
    input  game_status, speed, add_cube, apple_req, die_flash, score
  );
endinterface

// File: rtl/snake_flash_timer.sv
// snake_flash_timer: death blink generator; toggles flash every FLASH_HALF enabled cycles,
// raises done on the final toggle and leaves the snake visible.
module snake_flash_timer #(
  parameter int unsigned FLASH_HALF    = 12_500_000,
  parameter int unsigned FLASH_TOGGLES = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_en,
  output logic o_flash,
  output logic o_done
);
  localparam int CW = $clog2(FLASH_HALF + 1);
  localparam int TW = $clog2(FLASH_TOGGLES + 1);
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tog;
  logic          r_flash;
  logic          w_wrap;
  assign w_wrap  = i_en && r_cnt == CW'(FLASH_HALF - 1);
  assign o_done  = w_wrap && r_tog == TW'(FLASH_TOGGLES - 1);
  assign o_flash = r_flash;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt   <= '0;
      r_tog   <= '0;
      r_flash <= 1'b1;
    end else if (i_start) begin
      r_cnt   <= '0;
      r_tog   <= '0;
      r_flash <= 1'b1;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_tog   <= r_tog + 1'b1;
      r_flash <= o_done | ~r_flash;
    end else if (i_en) begin
      r_cnt   <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game-level sequencer driving status, step period, growth and death blink
// into the snake datapath.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter logic [40:0] STEP_BASE     = 41'd12_500_000,
  parameter logic [40:0] STEP_DEC      = 41'd1_000_000,
  parameter logic [40:0] STEP_MIN      = 41'd3_000_000,
  parameter int unsigned FLASH_HALF    = 12_500_000,
  parameter int unsigned FLASH_TOGGLES = 6,
  parameter int unsigned MAX_LEN       = 16
) (
  input logic clk,
  input logic rst,
  snake_game_ctrl_if.master io_bus
);
  state_t      r_state, w_next;
  logic [1:0]  r_status;
  logic [40:0] r_speed;
  logic [7:0]  r_score;
  logic        r_add, r_add_q, r_req;
  logic        w_hit, w_eat, w_rise, w_done, w_flash;
  assign w_hit  = io_bus.hit_wall | io_bus.hit_body;
  assign w_eat  = r_state == S_PLAY && io_bus.head_x == io_bus.apple_x &&
                  io_bus.head_y == io_bus.apple_y && io_bus.cube_num < 7'(MAX_LEN) && !w_hit;
  assign w_rise = r_add & ~r_add_q;
  always_comb
    w_next = r_state == S_RESTART ? S_READY :
             r_state == S_READY   ? (io_bus.start_press ? S_PLAY : S_READY) :
             r_state == S_PLAY    ? (w_hit ? S_DYING : io_bus.start_press ? S_PAUSE : S_PLAY) :
             r_state == S_PAUSE   ? (io_bus.start_press ? S_PLAY : S_PAUSE) :
             r_state == S_DYING   ? (w_done ? S_OVER : S_DYING) :
                                    (io_bus.start_press ? S_RESTART : S_OVER);
  snake_flash_timer #(.FLASH_HALF(FLASH_HALF), .FLASH_TOGGLES(FLASH_TOGGLES)) u_flash (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_state == S_PLAY && w_hit),
    .i_en    (r_state == S_DYING),
    .o_flash (w_flash),
    .o_done  (w_done)
  );
  // game stats are wiped on the edge entering S_RESTART so status 00 shows cleared values
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= S_RESTART;
      r_status <= ST_RESTART;
      r_speed  <= STEP_BASE;
      r_score  <= '0;
      r_add    <= 1'b0;
      r_add_q  <= 1'b0;
      r_req    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_status <= status_of(w_next);
      r_add    <= w_eat;
      r_add_q  <= r_add;
      r_req    <= w_rise;
      if (w_next == S_RESTART) begin
        r_speed <= STEP_BASE;
        r_score <= '0;
        r_add   <= 1'b0;
        r_add_q <= 1'b0;
        r_req   <= 1'b0;
      end else if (w_rise) begin
        r_speed <= next_speed(r_speed, STEP_DEC, STEP_MIN);
        r_score <= r_score + 8'(r_score != 8'hff);
      end
    end
  assign io_bus.game_status = r_status;
  assign io_bus.speed       = r_speed;
  assign io_bus.add_cube    = r_add;
  assign io_bus.apple_req   = r_req;
  assign io_bus.die_flash   = w_flash;
  assign io_bus.score       = r_score;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: table-driven directed vectors plus hand-written reset sequences
// for snake_game_ctrl with small step and blink constants.
module tb_snake_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  snake_game_ctrl_if bus ();
  snake_game_ctrl #(
    .STEP_BASE(41'd100), .STEP_DEC(41'd30), .STEP_MIN(41'd20),
    .FLASH_HALF(4), .FLASH_TOGGLES(6), .MAX_LEN(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );
  typedef struct {
    logic st, hw, hb, eat;
    logic [6:0] cube;
    logic [1:0] gs;
    logic [40:0] sp;
    logic ac, rq, fl;
    logic [7:0] sc;
  } vec_t;
  vec_t q[$];
  int n_pass = 0;
  int n_total = 0;
  task automatic chk(input string nm, input logic [40:0] act, input logic [40:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask
  task automatic v(input logic st, hw, hb, eat, input logic [6:0] cube, input logic [1:0] gs,
                   input logic [40:0] sp, input logic ac, rq, fl, input logic [7:0] sc);
    q.push_back('{st, hw, hb, eat, cube, gs, sp, ac, rq, fl, sc});
  endtask
  task automatic check_all(input string tag, input logic [1:0] gs, input logic [40:0] sp,
                           input logic ac, rq, fl, input logic [7:0] sc);
    chk({tag, " status"}, 41'(bus.game_status), 41'(gs));
    chk({tag, " speed"}, bus.speed, sp);
    chk({tag, " add_cube"}, 41'(bus.add_cube), 41'(ac));
    chk({tag, " apple_req"}, 41'(bus.apple_req), 41'(rq));
    chk({tag, " die_flash"}, 41'(bus.die_flash), 41'(fl));
    chk({tag, " score"}, 41'(bus.score), 41'(sc));
  endtask
  task automatic drive(input logic st, hw, hb, eat, input logic [6:0] cube);
    bus.start_press = st;
    bus.hit_wall    = hw;
    bus.hit_body    = hb;
    bus.head_x      = eat ? 7'd10 : 7'd5;
    bus.head_y      = eat ? 7'd10 : 7'd7;
    bus.apple_x     = 7'd10;
    bus.apple_y     = 7'd10;
    bus.cube_num    = cube;
  endtask
  task automatic run(input string phase);
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i].st, q[i].hw, q[i].hb, q[i].eat, q[i].cube);
      @(posedge clk);
      @(negedge clk);
      check_all($sformatf("%s row%0d", phase, i), q[i].gs, q[i].sp, q[i].ac, q[i].rq, q[i].fl, q[i].sc);
    end
    drive(0, 0, 0, 0, 7'd3);
    q.delete();
  endtask
  initial begin
    drive(0, 0, 0, 0, 7'd3);
    repeat (2) @(negedge clk);
    check_all("reset", 2'd0, 41'd100, 0, 0, 1, 8'd0);
    rst = 1'b1;
    v(0,0,0,0,3, 1,100,0,0,1,0);
    v(1,0,0,0,3, 2,100,0,0,1,0);
    v(0,0,0,0,3, 2,100,0,0,1,0);
    v(0,0,0,1,3, 2,100,1,0,1,0);
    v(0,0,0,1,3, 2,70,1,1,1,1);
    for (int k = 0; k < 3; k++) v(0,0,0,1,3, 2,70,1,0,1,1);
    v(0,0,0,0,3, 2,70,0,0,1,1);
    v(0,0,0,1,3, 2,70,1,0,1,1);
    v(0,0,0,0,3, 2,40,0,1,1,2);
    v(0,0,0,0,3, 2,40,0,0,1,2);
    v(0,0,0,1,3, 2,40,1,0,1,2);
    v(0,0,0,0,3, 2,20,0,1,1,3);
    v(0,0,0,1,3, 2,20,1,0,1,3);
    v(0,0,0,0,3, 2,20,0,1,1,4);
    v(0,0,0,1,16, 2,20,0,0,1,4);
    v(0,0,0,1,16, 2,20,0,0,1,4);
    v(1,0,0,0,3, 1,20,0,0,1,4);
    v(0,0,0,1,3, 1,20,0,0,1,4);
    v(1,0,0,1,3, 2,20,0,0,1,4);
    v(0,0,0,1,3, 2,20,1,0,1,4);
    v(0,0,0,0,3, 2,20,0,1,1,5);
    v(1,0,1,0,3, 3,20,0,0,1,5);
    for (int k = 1; k < 24; k++) v(k == 10,0,0,0,3, 3,20,0,0, ((k / 4) % 2) == 0, 5);
    v(0,0,0,0,3, 3,20,0,0,1,5);
    v(0,0,0,1,3, 3,20,0,0,1,5);
    v(1,0,0,0,3, 0,100,0,0,1,0);
    v(0,0,0,0,3, 1,100,0,0,1,0);
    v(1,0,0,0,3, 2,100,0,0,1,0);
    v(0,0,0,1,3, 2,100,1,0,1,0);
    v(0,0,0,0,3, 2,70,0,1,1,1);
    v(0,1,0,1,3, 3,70,0,0,1,1);
    v(0,0,0,0,3, 3,70,0,0,1,1);
    for (int k = 2; k < 6; k++) v(0,0,0,0,3, 3,70,0,0, k < 4, 1);
    run("game");
    #2 rst = 1'b0;
    #1 check_all("async_reset", 2'd0, 41'd100, 0, 0, 1, 8'd0);
    @(negedge clk);
    check_all("held_reset", 2'd0, 41'd100, 0, 0, 1, 8'd0);
    rst = 1'b1;
    v(0,0,0,0,3, 1,100,0,0,1,0);
    v(1,0,0,0,3, 2,100,0,0,1,0);
    v(0,0,0,1,3, 2,100,1,0,1,0);
    v(0,0,0,0,3, 2,70,0,1,1,1);
    run("after_reset");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
